// File: rtl/dav_rfd_fifo_buffer_pkg.sv
// Shared definitions for the dav_/rfd FIFO buffer: FSM state encodings and
// the active levels of the handshake signals.
package dav_rfd_fifo_buffer_pkg;

  typedef enum logic {
    IN_RDY = 1'b0,
    IN_ACK = 1'b1
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_W0   = 2'd1,
    OUT_W1   = 2'd2
  } out_state_t;

  // dav_ is active-low, rfd is active-high.
  localparam logic DAV_ACTIVE = 1'b0;
  localparam logic RFD_READY  = 1'b1;

endpackage

// File: rtl/dav_rfd_fifo_buffer_fifo_regfile.sv
// Storage array for the FIFO: one synchronous write port, one combinational
// read port. Contents are not reset; the pointers and count define validity.
module fifo_regfile #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Write the addressed entry when enabled.
  always_ff @(posedge clock) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/dav_rfd_fifo_buffer.sv
// DEPTH-entry FIFO between two dav_/rfd 4-phase handshake ports. The input
// FSM accepts words into the register file; the output FSM re-offers them in
// order on registered out_data/out_dav_. The full check uses registered count,
// so in_rfd rises no earlier than one edge after the freeing pop.
module dav_rfd_fifo_buffer
  import dav_rfd_fifo_buffer_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clock,
  input  logic          reset_,
  input  logic [W-1:0]  in_data,
  input  logic          in_dav_,
  output logic          in_rfd,
  output logic [W-1:0]  out_data,
  output logic          out_dav_,
  input  logic          out_rfd,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  in_state_t     r_in_state, w_in_state_nxt;
  out_state_t    r_out_state, w_out_state_nxt;
  logic          r_in_rfd, w_in_rfd_nxt;
  logic          r_out_dav_, w_out_dav_nxt;
  logic [W-1:0]  r_out_data, w_out_data_nxt;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop, w_not_full;
  logic [W-1:0]  w_rdata;

  fifo_regfile #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_regfile (
    .clock (clock),
    .we    (w_push),
    .waddr (r_wptr),
    .wdata (in_data),
    .raddr (r_rptr),
    .rdata (w_rdata)
  );

  assign w_not_full = (r_count < CW'(DEPTH));

  // Input handshake: take a word in IN_RDY, release the producer once dav_
  // is withdrawn and there is room for the next word.
  always_comb begin
    w_in_state_nxt = r_in_state;
    w_in_rfd_nxt   = r_in_rfd;
    w_push         = 1'b0;
    case (r_in_state)
      IN_RDY: begin
        if (in_dav_ == DAV_ACTIVE) begin
          w_push         = 1'b1;
          w_in_rfd_nxt   = ~RFD_READY;
          w_in_state_nxt = IN_ACK;
        end
      end
      IN_ACK: begin
        if ((in_dav_ != DAV_ACTIVE) && w_not_full) begin
          w_in_rfd_nxt   = RFD_READY;
          w_in_state_nxt = IN_RDY;
        end
      end
      default: begin
        w_in_rfd_nxt   = RFD_READY;
        w_in_state_nxt = IN_RDY;
      end
    endcase
  end

  // Output handshake: present the head word, pop on consumer acknowledge,
  // then wait for the consumer to return to ready before the next word.
  always_comb begin
    w_out_state_nxt = r_out_state;
    w_out_dav_nxt   = r_out_dav_;
    w_out_data_nxt  = r_out_data;
    w_pop           = 1'b0;
    case (r_out_state)
      OUT_IDLE: begin
        if (r_count != '0) begin
          w_out_data_nxt  = w_rdata;
          w_out_dav_nxt   = DAV_ACTIVE;
          w_out_state_nxt = OUT_W0;
        end
      end
      OUT_W0: begin
        if (out_rfd != RFD_READY) begin
          w_pop           = 1'b1;
          w_out_dav_nxt   = ~DAV_ACTIVE;
          w_out_state_nxt = OUT_W1;
        end
      end
      OUT_W1: begin
        if (out_rfd == RFD_READY) w_out_state_nxt = OUT_IDLE;
      end
      default: begin
        w_out_dav_nxt   = ~DAV_ACTIVE;
        w_out_state_nxt = OUT_IDLE;
      end
    endcase
  end

  // State, handshake outputs, pointers and occupancy count.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_in_state  <= IN_RDY;
      r_out_state <= OUT_IDLE;
      r_in_rfd    <= RFD_READY;
      r_out_dav_  <= ~DAV_ACTIVE;
      r_out_data  <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else begin
      r_in_state  <= w_in_state_nxt;
      r_out_state <= w_out_state_nxt;
      r_in_rfd    <= w_in_rfd_nxt;
      r_out_dav_  <= w_out_dav_nxt;
      r_out_data  <= w_out_data_nxt;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count     <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign in_rfd   = r_in_rfd;
  assign out_dav_ = r_out_dav_;
  assign out_data = r_out_data;
  assign count    = r_count;

endmodule
